multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle main control decoder. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and write-back. It drives a shared ALU, instruction register and unified memory over a request/ready handshake, with a parametrised wait-state timeout and illegal-opcode trapping. It sits between the instruction register opcode/funct fields and the multi-cycle datapath.

---
 rtl/multicycle_control.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Moore-style main control FSM for a multi-cycle datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and write-back states.
// The controller drives a shared ALU, the instruction register and a unified
// memory.
//
// Memory handshake: mem_req is held high for the whole time the FSM sits in
// FETCH, MEMRD or MEMWR. A transfer completes in the cycle where mem_req and
// mem_ready are both high, and the FSM leaves the memory state on the
// following edge. mem_req is never dropped while waiting for mem_ready.
//
// Parameters:
//   MAX_WAIT  consecutive unanswered request cycles tolerated before HALT
//             (0 disables the timeout)
//   EXT_EN    1 makes NANDI (opcode 010000) legal; 0 traps it as illegal
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   in, funct      opcode / funct fields from the instruction register
//   mem_ready      memory completes the current request this cycle
//   mem_req, mem_write, iord                 memory request controls
//   ir_write, pc_write, pc_write_cond, pc_source   IR / PC controls
//   alu_src_a, alu_src_b, alu_op             ALU operand and operation select
//   reg_dest, mem_to_reg, reg_write          register file controls
//   illegal        one-cycle pulse in DECODE on an undecodable opcode
//   mem_timeout    high while in HALT after a wait-state timeout
//   state          current state encoding (debug)
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter bit EXT_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] in,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NANDI = 6'b010000;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_EXEC_I  = 4'd11,
    S_IWB     = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            waiting;

  // funct is interpreted by the downstream ALU control when alu_op = 100;
  // this FSM does not branch on it.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (waiting && !mem_ready && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    waiting       = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dest      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    mem_timeout   = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        waiting   = 1'b1;
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only in the cycle the fetch actually completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (in)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_NANDI: begin
            if (EXT_EN) begin
              state_d = S_EXEC_I;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (in == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        waiting = 1'b1;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        waiting   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
        state_d   = S_RWB;
      end

      S_RWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        state_d   = S_IWB;
      end

      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: mem_timeout = 1'b1;

      default: state_d = S_INIT;
    endcase

    // Timeout: a mem_ready in the same cycle wins, so this only fires while
    // the request is still unanswered.
    if ((MAX_WAIT > 0) && waiting && !mem_ready && (cnt_q == MAX_CNT)) begin
      state_d = S_HALT;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control.
// dut_a: MAX_WAIT=3, EXT_EN=1.  dut_b: MAX_WAIT=0 (no timeout), EXT_EN=0.
// Each driven cycle pushes {dut select, expected state, expected outputs}
// into exp_q; the monitor pops one entry per falling edge and compares it
// against the selected DUT.
module tb_multicycle_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_NI  = 6'b010000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] in = '0;
  logic [5:0] funct = 6'h20;
  logic       mem_ready = 1'b0;

  logic       a_mem_req, a_mem_write, a_iord, a_ir_write, a_pc_write, a_pc_write_cond;
  logic [1:0] a_pc_source, a_alu_src_b;
  logic       a_alu_src_a, a_reg_dest, a_mem_to_reg, a_reg_write, a_illegal, a_mem_timeout;
  logic [2:0] a_alu_op;
  logic [3:0] a_state;

  logic       b_mem_req, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_write_cond;
  logic [1:0] b_pc_source, b_alu_src_b;
  logic       b_alu_src_a, b_reg_dest, b_mem_to_reg, b_reg_write, b_illegal, b_mem_timeout;
  logic [2:0] b_alu_op;
  logic [3:0] b_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic [W-2:0] act_a, act_b, act;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(3), .EXT_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in(in), .funct(funct), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .iord(a_iord),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond),
    .pc_source(a_pc_source), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .reg_dest(a_reg_dest), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .illegal(a_illegal), .mem_timeout(a_mem_timeout),
    .state(a_state)
  );

  multicycle_control #(.MAX_WAIT(0), .EXT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in(in), .funct(funct), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .iord(b_iord),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
    .pc_source(b_pc_source), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .reg_dest(b_reg_dest), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .illegal(b_illegal), .mem_timeout(b_mem_timeout),
    .state(b_state)
  );

  assign act_a = {a_state, a_mem_req, a_mem_write, a_iord, a_ir_write, a_pc_write,
                  a_pc_write_cond, a_pc_source, a_alu_src_a, a_alu_src_b, a_alu_op,
                  a_reg_dest, a_mem_to_reg, a_reg_write, a_illegal, a_mem_timeout};
  assign act_b = {b_state, b_mem_req, b_mem_write, b_iord, b_ir_write, b_pc_write,
                  b_pc_write_cond, b_pc_source, b_alu_src_a, b_alu_src_b, b_alu_op,
                  b_reg_dest, b_mem_to_reg, b_reg_write, b_illegal, b_mem_timeout};

  // Expected output table per state, written from the state/output list.
  // Field order: mem_req mem_write iord ir_write pc_write pc_write_cond
  //              pc_source[2] alu_src_a alu_src_b[2] alu_op[3]
  //              reg_dest mem_to_reg reg_write illegal mem_timeout
  function automatic logic [18:0] outs_for(input logic [3:0] st, input logic rdy,
                                           input logic ill);
    logic mr, mw, io, irw, pcw, pcc, asa, rd, m2r, rw, il, to;
    logic [1:0] ps, asb;
    logic [2:0] aop;
    {mr, mw, io, irw, pcw, pcc, asa, rd, m2r, rw, il, to} = '0;
    ps = 2'b00; asb = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd2:  begin asb = 2'b11; il = ill; end
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mr = 1; io = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mr = 1; mw = 1; io = 1; end
      4'd7:  begin asa = 1; aop = 3'b100; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin asa = 1; aop = 3'b001; pcc = 1; ps = 2'b01; end
      4'd10: begin pcw = 1; ps = 2'b10; end
      4'd11: begin asa = 1; asb = 2'b10; aop = 3'b011; end
      4'd12: begin rw = 1; end
      4'd13: begin to = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, pcc, ps, asa, asb, aop, rd, m2r, rw, il, to};
  endfunction

  // Driver: one call per clock cycle. Inputs change 1 time unit after the
  // rising edge; st is the state expected to be visible during this cycle.
  task automatic s(input logic sel, input logic rst, input logic rdy,
                   input logic [5:0] op, input logic [3:0] st, input logic ill);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    in        = op;
    exp_q.push_back({sel, st, outs_for(st, rdy, ill)});
  endtask

  task automatic m(input logic rdy, input logic [5:0] op, input logic [3:0] st);
    s(1'b0, 1'b0, rdy, op, st, 1'b0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      act   = exp_e[W-1] ? act_b : act_a;
      checks++;
      if (act !== exp_e[W-2:0]) begin
        errors++;
        $display("FAIL check %0d dut_%s: got state=%0d outs=%b, expected state=%0d outs=%b",
                 checks, exp_e[W-1] ? "b" : "a", act[22:19], act[18:0],
                 exp_e[22:19], exp_e[18:0]);
      end
    end
  end

  initial begin
    // Reset state, then release: INIT for one cycle, then FETCH.
    s(0, 1, 0, OP_R, 4'd0, 0);
    s(0, 0, 1, OP_LW, 4'd0, 0);
    // LW, zero wait: 1,2,3,4,5
    m(1, OP_LW, 4'd1); m(1, OP_LW, 4'd2); m(1, OP_LW, 4'd3);
    m(1, OP_LW, 4'd4); m(1, OP_LW, 4'd5);
    // SW with two wait cycles in MEMWR: 6 cycles
    m(1, OP_SW, 4'd1); m(1, OP_SW, 4'd2); m(1, OP_SW, 4'd3);
    m(0, OP_SW, 4'd6); m(0, OP_SW, 4'd6); m(1, OP_SW, 4'd6);
    // R-type then BEQ back to back
    m(1, OP_R, 4'd1); m(1, OP_R, 4'd2); m(1, OP_R, 4'd7); m(1, OP_R, 4'd8);
    m(1, OP_BEQ, 4'd1); m(1, OP_BEQ, 4'd2); m(1, OP_BEQ, 4'd9);
    // J
    m(1, OP_J, 4'd1); m(1, OP_J, 4'd2); m(1, OP_J, 4'd10);
    // NANDI with EXT_EN=1
    m(1, OP_NI, 4'd1); m(1, OP_NI, 4'd2); m(1, OP_NI, 4'd11); m(1, OP_NI, 4'd12);
    // Illegal opcode: one-cycle pulse in DECODE, FETCH follows
    m(1, OP_BAD, 4'd1); s(0, 0, 1, OP_BAD, 4'd2, 1);
    // mem_ready arrives in the 4th fetch cycle: no timeout
    m(0, OP_J, 4'd1); m(0, OP_J, 4'd1); m(0, OP_J, 4'd1); m(1, OP_J, 4'd1);
    m(1, OP_J, 4'd2); m(1, OP_J, 4'd10);
    // Fetch timeout: 4 request cycles, then HALT for 20+ cycles
    m(0, OP_R, 4'd1); m(0, OP_R, 4'd1); m(0, OP_R, 4'd1); m(0, OP_R, 4'd1);
    for (int i = 0; i < 21; i++) m(i[0], OP_R, 4'd13);
    // Reset out of HALT clears mem_timeout
    s(0, 1, 0, OP_R, 4'd0, 0);
    s(0, 0, 0, OP_LW, 4'd0, 0);
    // Reset mid-MEMRD: outputs drop in the same cycle
    m(1, OP_LW, 4'd1); m(1, OP_LW, 4'd2); m(1, OP_LW, 4'd3);
    m(0, OP_LW, 4'd4); m(0, OP_LW, 4'd4);
    s(0, 1, 0, OP_LW, 4'd0, 0);
    s(0, 0, 0, OP_R, 4'd0, 0);
    // Counter restarted from 0: three waits plus ready still fetches
    m(0, OP_R, 4'd1); m(0, OP_R, 4'd1); m(0, OP_R, 4'd1); m(1, OP_R, 4'd1);
    m(1, OP_R, 4'd2); m(1, OP_R, 4'd7); m(1, OP_R, 4'd8);
    // Timeout from MEMRD
    m(1, OP_LW, 4'd1); m(1, OP_LW, 4'd2); m(1, OP_LW, 4'd3);
    m(0, OP_LW, 4'd4); m(0, OP_LW, 4'd4); m(0, OP_LW, 4'd4); m(0, OP_LW, 4'd4);
    m(0, OP_LW, 4'd13); m(1, OP_LW, 4'd13);

    // dut_b: EXT_EN=0 traps NANDI; MAX_WAIT=0 never times out
    s(1, 1, 0, OP_NI, 4'd0, 0);
    s(1, 0, 1, OP_NI, 4'd0, 0);
    s(1, 0, 1, OP_NI, 4'd1, 0);
    s(1, 0, 1, OP_NI, 4'd2, 1);
    for (int i = 0; i < 20; i++) s(1, 0, 0, OP_R, 4'd1, 0);
    s(1, 0, 1, OP_R, 4'd1, 0);
    s(1, 0, 1, OP_R, 4'd2, 0);
    s(1, 0, 1, OP_R, 4'd7, 0);
    s(1, 0, 1, OP_R, 4'd8, 0);
    s(1, 0, 1, OP_SW, 4'd1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
